// File: rtl/led_pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_pwm_pkg : shared constants and helpers for the LED PWM fader |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package led_pwm_pkg;

    localparam int DEF_DUTY_W = 8;

    typedef logic [DEF_DUTY_W-1:0] duty_t;

    // Largest duty code for a given PWM resolution.
    function automatic int dmax(input int w);
        return (1 << w) - 1;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_fader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_pwm_fader_if : request/enable inputs and LED drive outputs   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface led_pwm_fader_if #(
    parameter int NUM_CH = 8
);
    logic [NUM_CH-1:0] led_req;
    logic              enable;
    logic [NUM_CH-1:0] led_out;
    logic              busy;
    logic              frame_start;

    modport master (
        output led_req,
        output enable,
        input  led_out,
        input  busy,
        input  frame_start
    );

    modport slave (
        input  led_req,
        input  enable,
        output led_out,
        output busy,
        output frame_start
    );
endinterface
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_fade_channel : one LED's duty ramp and registered PWM drive  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module led_fade_channel
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_req,
    input  wire logic              i_ramp,
    input  wire logic              i_enable,
    input  wire logic [DUTY_W-1:0] i_pwm_cnt,
    output logic                   o_led,
    output logic                   o_mismatch
);

    localparam logic [DUTY_W-1:0] c_dmax = DUTY_W'(dmax(DUTY_W));

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              led_q, led_d;
    logic [DUTY_W-1:0] w_target;

    always_comb begin
        w_target = i_req ? c_dmax : '0;
        duty_d   = duty_q;
        led_d    = 1'b0;

        // Target is always 0 or DMAX, so stepping toward it saturates naturally.
        if (i_ramp) begin
            if (duty_q < w_target) begin
                duty_d = duty_q + DUTY_W'(1);
            end else if (duty_q > w_target) begin
                duty_d = duty_q - DUTY_W'(1);
            end
        end

        if (i_enable) begin
            if (duty_q == c_dmax) begin
                led_d = 1'b1;
            end else begin
                led_d = (i_pwm_cnt < duty_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign o_led      = led_q;
    assign o_mismatch = (duty_q != w_target);

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | led_pwm_fader : PWM LED driver fading each pin toward its request|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DUTY_W   = 8,
    parameter int PRESCALE = 195,
    parameter int RAMP_DIV = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    led_pwm_fader_if.slave bus
);

    localparam int                c_pw         = cnt_w(PRESCALE);
    localparam int                c_rw         = cnt_w(RAMP_DIV);
    localparam logic [c_pw-1:0]   c_presc_last = c_pw'(PRESCALE - 1);
    localparam logic [c_rw-1:0]   c_div_last   = c_rw'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] c_dmax       = DUTY_W'(dmax(DUTY_W));

    logic [NUM_CH-1:0] req_q, req_d;
    logic [c_pw-1:0]   presc_q, presc_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [c_rw-1:0]   div_q, div_d;
    logic              busy_q, busy_d;
    logic              frame_start_q, frame_start_d;

    logic              w_step;
    logic              w_frame_end;
    logic              w_ramp;
    logic [NUM_CH-1:0] w_mismatch;
    logic [NUM_CH-1:0] w_led;

    always_comb begin
        req_d       = bus.led_req;

        w_step      = (presc_q == c_presc_last);
        presc_d     = w_step ? '0 : presc_q + c_pw'(1);
        pwm_cnt_d   = w_step ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        w_frame_end = w_step && (pwm_cnt_q == c_dmax);

        div_d = div_q;
        if (w_frame_end) begin
            div_d = (div_q == c_div_last) ? '0 : div_q + c_rw'(1);
        end
        // Duties only move at a frame boundary, so a frame never changes shape mid-way.
        w_ramp = w_frame_end && (div_q == c_div_last);

        frame_start_d = w_frame_end;
        busy_d        = |w_mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q         <= '0;
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            div_q         <= '0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            req_q         <= req_d;
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            div_q         <= div_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        led_fade_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_req      (req_q[gi]),
            .i_ramp     (w_ramp),
            .i_enable   (bus.enable),
            .i_pwm_cnt  (pwm_cnt_q),
            .o_led      (w_led[gi]),
            .o_mismatch (w_mismatch[gi])
        );
    end

    assign bus.led_out     = w_led;
    assign bus.busy        = busy_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_led_pwm_fader : directed checks of fade, blanking and reset   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_led_pwm_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    led_pwm_fader_if #(.NUM_CH(8)) ifa ();
    led_pwm_fader_if #(.NUM_CH(8)) ifb ();

    led_pwm_fader #(
        .NUM_CH(8), .DUTY_W(3), .PRESCALE(2), .RAMP_DIV(1)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    led_pwm_fader #(
        .NUM_CH(8), .DUTY_W(3), .PRESCALE(2), .RAMP_DIV(3)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       en;
        logic [7:0] exp_led;
        logic       exp_busy;
        logic       exp_fs;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a(input logic [7:0] req);
        rst_a       = 1'b1;
        ifa.led_req = req;
        ifa.enable  = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic wait_fs(output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            n++;
            if (ifa.frame_start) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_fs timeout actual=%0d cycles required=frame_start", n);
        end
    endtask

    // One 16-cycle frame window on dut_a: high count of one bit plus status snapshots.
    task automatic measure(input int bsel, output int hi, output logic bf,
                           output logic bl, output logic fl, output int stray);
        hi    = 0;
        stray = 0;
        bf    = 1'b0;
        bl    = 1'b0;
        fl    = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (ifa.led_out[bsel]) hi++;
            if ((ifa.led_out & ~(8'h01 << bsel)) != 8'h00) stray++;
            if (t == 1) bf = ifa.busy;
            if (t == 16) begin
                bl = ifa.busy;
                fl = ifa.frame_start;
            end
        end
    endtask

    function automatic vec_t mk(logic rst, logic [7:0] req, logic [7:0] el, logic eb, logic ef);
        vec_t v;
        v.rst      = rst;
        v.req      = req;
        v.en       = 1'b1;
        v.exp_led  = el;
        v.exp_busy = eb;
        v.exp_fs   = ef;
        return v;
    endfunction

    initial begin
        int   n, hi, stray, stray_tot, nz, fsn, last, gap, hi1, hi2, lock_err;
        logic bf, bl, fl, b336, b337;
        int   exp_hi[5];

        rst_a       = 1'b1;
        rst_b       = 1'b1;
        ifa.led_req = 8'h00;
        ifa.enable  = 1'b1;
        ifb.led_req = 8'hFF;
        ifb.enable  = 1'b1;

        // Reset held 3 cycles with all requests on, then the first frame of the fade.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0));
        for (int j = 2; j <= 15; j++) vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0));

        foreach (vecs[i]) begin
            rst_a       = vecs[i].rst;
            ifa.led_req = vecs[i].req;
            ifa.enable  = vecs[i].en;
            tick();
            check($sformatf("v%0d led_out", i), 32'(ifa.led_out), 32'(vecs[i].exp_led));
            check($sformatf("v%0d busy", i), 32'(ifa.busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d frame_start", i), 32'(ifa.frame_start), 32'(vecs[i].exp_fs));
        end

        // Fade up on channel 0.
        reset_a(8'h01);
        wait_fs(n);
        check("fade_up first frame_start latency", n, 16);
        stray_tot = 0;
        for (int f = 1; f <= 7; f++) begin
            measure(0, hi, bf, bl, fl, stray);
            stray_tot += stray;
            check($sformatf("fade_up duty%0d high cycles", f), hi, (f == 7) ? 16 : 2 * f);
            check($sformatf("fade_up duty%0d frame_start period", f), 32'(fl), 1);
            check($sformatf("fade_up duty%0d busy", f), 32'(bf), (f < 7) ? 1 : 0);
        end
        check("fade_up busy at end", 32'(ifa.busy), 0);
        check("fade_up bits 7:1 stray", stray_tot, 0);

        // Reversal when duty reaches 4.
        reset_a(8'h01);
        wait_fs(n);
        for (int f = 1; f <= 3; f++) begin
            measure(0, hi, bf, bl, fl, stray);
            check($sformatf("rev up duty%0d high cycles", f), hi, 2 * f);
        end
        ifa.led_req = 8'h00;
        exp_hi = '{8, 6, 4, 2, 0};
        for (int w = 0; w < 5; w++) begin
            measure(0, hi, bf, bl, fl, stray);
            check($sformatf("rev window%0d high cycles", w), hi, exp_hi[w]);
            check($sformatf("rev window%0d busy first", w), 32'(bf), (w < 4) ? 1 : 0);
            check($sformatf("rev window%0d busy last", w), 32'(bl), (w < 4) ? 1 : 0);
        end

        // Enable blanking with all channels full on.
        reset_a(8'hFF);
        for (int f = 0; f < 8; f++) wait_fs(n);
        tick();
        tick();
        check("blank pre led_out", 32'(ifa.led_out), 32'hFF);
        ifa.enable = 1'b0;
        nz   = 0;
        fsn  = 0;
        last = -1;
        gap  = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (ifa.led_out != 8'h00) nz++;
            if (ifa.frame_start) begin
                if (last >= 0) gap = t - last;
                last = t;
                fsn++;
            end
        end
        check("blank led_out nonzero cycles", nz, 0);
        check("blank frame_start count", fsn, 2);
        check("blank frame_start spacing", gap, 16);
        ifa.enable = 1'b1;
        tick();
        check("blank re-enable led_out", 32'(ifa.led_out), 32'hFF);

        // Reset while channel 2 is mid-fade at duty 5.
        reset_a(8'h04);
        for (int f = 0; f < 5; f++) wait_fs(n);
        tick();
        tick();
        tick();
        check("midreset busy before", 32'(ifa.busy), 1);
        rst_a = 1'b1;
        tick();
        check("midreset led_out", 32'(ifa.led_out), 0);
        check("midreset busy", 32'(ifa.busy), 0);
        check("midreset frame_start", 32'(ifa.frame_start), 0);
        rst_a = 1'b0;
        nz = 0;
        fl = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (ifa.led_out != 8'h00) nz++;
            if (t == 16) fl = ifa.frame_start;
        end
        check("midreset duty0 frame led_out", nz, 0);
        check("midreset first frame_start", 32'(fl), 1);
        measure(2, hi, bf, bl, fl, stray);
        check("midreset restart duty1 high cycles", hi, 2);
        check("midreset restart stray bits", stray, 0);

        // RAMP_DIV=3 instance: one duty step per three frames, all channels in lockstep.
        tick();
        rst_b    = 1'b0;
        hi1      = 0;
        hi2      = 0;
        fsn      = 0;
        lock_err = 0;
        b336     = 1'b0;
        b337     = 1'b1;
        for (int k = 1; k <= 340; k++) begin
            tick();
            if (ifb.led_out != 8'h00 && ifb.led_out != 8'hFF) lock_err++;
            if (k >= 49 && k <= 96 && ifb.led_out[0]) hi1++;
            if (k >= 97 && k <= 144 && ifb.led_out[0]) hi2++;
            if (ifb.frame_start) fsn++;
            if (k == 336) b336 = ifb.busy;
            if (k == 337) b337 = ifb.busy;
        end
        check("div3 lockstep violations", lock_err, 0);
        check("div3 duty1 three-frame high cycles", hi1, 6);
        check("div3 duty2 three-frame high cycles", hi2, 12);
        check("div3 frame_start count", fsn, 21);
        check("div3 busy last frame", 32'(b336), 1);
        check("div3 busy after full", 32'(b337), 0);
        check("div3 final led_out", 32'(ifb.led_out), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
